// File: rtl/rr_switch_mux.sv
// Round-robin NoC output-port switch with wormhole packet locking,
// a valid/ready handshake and one registered output stage.
module rr_switch_mux #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 4,
  parameter int SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS-1:0]        req_tail_i,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  output logic [NUM_PORTS-1:0]        req_ready_o,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o,
  output logic                        tail_o,
  output logic [SEL_W-1:0]            sel_o,
  input  logic                        ready_i,
  output logic                        locked_o
);

  logic              valid_q, valid_d;
  logic              tail_q, tail_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  lock_port_q, lock_port_d;

  logic              load_en;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic              accept;

  assign load_en = !valid_q || ready_i;
  assign accept  = load_en && grant_vld;

  // Reverse scan so the port closest to ptr is the last writer and wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (locked_q) begin
      grant_vld = req_valid_i[lock_port_q];
      grant_idx = lock_port_q;
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (req_valid_i[SEL_W'(idx)]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int g = 0; g < NUM_PORTS; g++) begin
      if (accept && !rst_i && grant_idx == SEL_W'(g))
        req_ready_o[g] = 1'b1;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    tail_d      = tail_q;
    sel_d       = sel_q;
    locked_d    = locked_q;
    ptr_d       = ptr_q;
    lock_port_d = lock_port_q;
    if (load_en) valid_d = accept;
    if (accept) begin
      data_d = data_i[int'(grant_idx)*DATA_W +: DATA_W];
      tail_d = req_tail_i[grant_idx];
      sel_d  = grant_idx;
      if (req_tail_i[grant_idx]) begin
        locked_d = 1'b0;
        if (grant_idx == SEL_W'(NUM_PORTS - 1)) ptr_d = '0;
        else ptr_d = grant_idx + SEL_W'(1);
      end else begin
        locked_d    = 1'b1;
        lock_port_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      tail_q      <= 1'b0;
      sel_q       <= '0;
      locked_q    <= 1'b0;
      ptr_q       <= '0;
      lock_port_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      tail_q      <= tail_d;
      sel_q       <= sel_d;
      locked_q    <= locked_d;
      ptr_q       <= ptr_d;
      lock_port_q <= lock_port_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign tail_o   = tail_q;
  assign sel_o    = sel_q;
  assign locked_o = locked_q;

endmodule

// File: doc/rr_switch_mux.md
# rr_switch_mux

Parametrised round-robin output-port switch for the NoC router: arbitrates among `NUM_PORTS` input channels, multiplexes the winning channel's flit onto a registered output, and holds the grant for a whole wormhole packet until its tail flit. It is the next generation of the router's 5:1 output multiplexer and sits one per router output port, between the input buffers and the link. It adds arbitration, packet locking, a valid/ready handshake and one output pipeline register. The default configuration uses N=0, S=1, W=2, E=3, L=4 port indices.

## Interface
- `NUM_PORTS`, default 5: number of input channels; must be at least 1.
- `DATA_W`, default 4: flit width in bits.
- `SEL_W`, default derived: equals max(1, $clog2(NUM_PORTS)).
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `req_valid_i` input NUM_PORTS: per-port flit valid.
- `req_tail_i` input NUM_PORTS: per-port flag marking the last flit of a packet.
- `data_i` input NUM_PORTS*DATA_W: flattened flits; port p occupies [p*DATA_W +: DATA_W].
- `req_ready_o` output NUM_PORTS: per-port accept; a flit is transferred when valid and ready are both high.
- `data_o` output DATA_W: registered output flit.
- `valid_o` output 1: output flit valid.
- `tail_o` output 1: output flit is a tail.
- `sel_o` output SEL_W: index of the source port of the flit currently in the output register.
- `ready_i` input 1: downstream accept.
- `locked_o` output 1: a multi-flit packet currently owns the switch.

## Operation
- `load_en` = !valid_o || ready_i. The output register may load in any cycle where `load_en` is high.
- Unlocked arbitration: scan ports ptr, ptr+1, …, wrapping modulo NUM_PORTS. Grant the first port with `req_valid_i` high.
- Locked arbitration: only `lock_port` is eligible. All other ports receive `req_ready_o`=0, even when the locked port's valid is low (bubbles are allowed; no interleaving).
- `req_ready_o[g]` = `load_en` && a grant exists && port == g. This is combinational. At most one bit is high, and all bits are 0 while `rst_i` is high.
- On an accepted flit from port g:
  - `data_o` ← data_i[g], `tail_o` ← req_tail_i[g], `sel_o` ← g, `valid_o` ← 1.
- Packet state update on acceptance:
  - Tail=0: `locked_o` ← 1 and `lock_port` ← g.
  - Tail=1: `locked_o` ← 0 and ptr ← (g+1) mod NUM_PORTS. A single-flit packet therefore never locks.
- If `load_en` is high and no flit is accepted, `valid_o` ← 0. `data_o`, `tail_o` and `sel_o` hold their previous values.
- Upstream must keep valid and data stable until the flit is accepted. Behaviour otherwise is not required to be lossless.
- ptr does not advance on non-tail flits. A wormhole packet does not consume extra turns.

## Timing
- Reset values (asynchronous): `valid_o`=0, `data_o`=0, `tail_o`=0, `sel_o`=0, `locked_o`=0, ptr=0, `lock_port`=0, `req_ready_o`=0.
- Latency: a flit accepted in cycle t appears on `data_o` with `valid_o`=1 in cycle t+1.
- Throughput: with `ready_i` held high, the switch carries 1 flit per cycle.
- Simultaneous drain and load: when `valid_o`=1 and `ready_i`=1 in the same cycle a new flit is accepted, the output register is replaced with no bubble.
- Backpressure: while `valid_o`=1 and `ready_i`=0, all outputs are held stable and `req_ready_o` is all-zero.
- Reset mid-packet:
  - The lock and the output register clear immediately.
  - Any flit held in the output register is discarded.
  - Arbitration restarts at port 0 on the first cycle after `rst_i` falls.
- Wrap-around: with ptr=NUM_PORTS-1, the scan order is NUM_PORTS-1, 0, 1, ….
- NUM_PORTS=1: `sel_o` is always 0 and the lock still follows the tail.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle with traffic present → all outputs read 0 immediately; first grant after release goes to the lowest-indexed valid port.
- **Round-robin fairness:** all 5 ports valid with single-flit packets (tail=1), data_i[p]=p+1, `ready_i`=1 → `data_o` sequence 1,2,3,4,5,1 on consecutive cycles, with `sel_o` 0,1,2,3,4,0.
- **Wormhole lock:**
  - Stimulus: port 2 sends a 3-flit packet (A,B,C; tail on C) while port 0 is continuously valid with data D.
  - Required response: `data_o` shows A,B,C back-to-back with `locked_o`=1 after A and after B; `locked_o` returns to 0 after C; port 0 receives no ready until C is accepted; D follows C on the next cycle.
- **Backpressure:** with `valid_o`=1 and `data_o`=9, hold `ready_i`=0 for 3 cycles → `data_o`, `sel_o` and `tail_o` stay stable and `req_ready_o`=0; `ready_i`=1 → the next flit loads in the same cycle.
- **Locked bubble:**
  - Stimulus: port 1 sends its head flit (tail=0), then drops valid for 2 cycles while port 3 is valid, then sends its tail flit.
  - Required response: `valid_o`=0 for 2 cycles; port 3 is not granted until the cycle after port 1's tail is accepted.
- **Reset mid-packet:** port 4 head flit accepted, then `rst_i` pulsed → `locked_o`=0; after release, port 0 (valid) wins over port 4.
